// File: rtl/count_snapshot_fifo_pkg.sv
// Shared widths and types for the count snapshot FIFO.
//   CNT_W   : upstream counter width
//   EPOCH_W : wrap counter width
//   DEPTH   : FIFO entries (power of 2)
//   ADDR_W  : log2(DEPTH)
//   TS_W    : timestamp width {epoch, count}
package count_snapshot_pkg;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned EPOCH_W = 5;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned TS_W    = EPOCH_W + CNT_W;

  typedef logic [TS_W-1:0] ts_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/count_snapshot_fifo_fifo.sv
// Synchronous show-ahead FIFO: head entry is always visible on rdata.
// Ports:
//   clock, clear : clock and synchronous active-high reset
//   push, wdata  : write request and data (caller guarantees space)
//   pop          : remove head (caller guarantees non-empty)
//   rdata        : head entry, straight from storage registers
//   level        : entries held, 0..DEPTH
//   empty, full  : level == 0 / level == DEPTH
module snapshot_fifo
  import count_snapshot_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic            push,
  input  ts_t             wdata,
  input  logic            pop,
  output ts_t             rdata,
  output logic [ADDR_W:0] level,
  output logic            empty,
  output logic            full
);

  ts_t               r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_level;

  // Storage is cleared too so the head reads zero after reset.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[ADDR_W'(i)] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign level = r_level;
  assign empty = (r_level == '0);
  assign full  = (r_level == (ADDR_W+1)'(DEPTH));

endmodule

// File: rtl/count_snapshot_fifo.sv
// Extends a free-running counter into a {epoch, count} timestamp, captures it
// on each rising edge of event_in and queues captures in a show-ahead FIFO.
// Ports:
//   clock, clear          : clock and synchronous active-high reset
//   count_in              : upstream counter value
//   event_in              : capture request (level; rising edge captures)
//   out_data/valid/ready  : head entry handshake to the next stage
//   level                 : entries held
//   overflow              : sticky, a capture was dropped on a full FIFO
//   wrap_pulse            : one-cycle pulse after a counter wrap
module count_snapshot_fifo
  import count_snapshot_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic [CNT_W-1:0] count_in,
  input  logic             event_in,
  output ts_t              out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADDR_W:0]  level,
  output logic             overflow,
  output logic             wrap_pulse
);

  logic [CNT_W-1:0]   r_prev_count;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_event_d;
  logic               r_overflow;
  logic               r_wrap_pulse;

  logic               w_wrap;
  logic [EPOCH_W-1:0] w_epoch_nxt;
  ts_t                w_ts;
  logic               w_cap;
  logic               w_pop;
  logic               w_push;
  logic               w_empty;
  logic               w_full;

  // A capture coincident with a wrap carries the new epoch, keeping timestamps monotonic.
  assign w_wrap      = (r_prev_count == CNT_MAX) && (count_in == '0);
  assign w_epoch_nxt = w_wrap ? r_epoch + EPOCH_W'(1) : r_epoch;
  assign w_ts        = {w_epoch_nxt, count_in};

  // Push is allowed on a full FIFO only when the head leaves in the same cycle.
  assign w_cap  = event_in & ~r_event_d;
  assign w_pop  = ~w_empty & out_ready;
  assign w_push = w_cap & (~w_full | w_pop);

  // Wrap tracking, edge detect and sticky overflow.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_prev_count <= '0;
      r_epoch      <= '0;
      r_event_d    <= 1'b0;
      r_overflow   <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_prev_count <= count_in;
      r_epoch      <= w_epoch_nxt;
      r_event_d    <= event_in;
      r_wrap_pulse <= w_wrap;
      if (w_cap && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  snapshot_fifo u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (w_push),
    .wdata (w_ts),
    .pop   (w_pop),
    .rdata (out_data),
    .level (level),
    .empty (w_empty),
    .full  (w_full)
  );

  assign out_valid  = ~w_empty;
  assign overflow   = r_overflow;
  assign wrap_pulse = r_wrap_pulse;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo; count_in is a free-running 0..7 counter.
module tb_count_snapshot_fifo;
  import count_snapshot_pkg::*;

  logic             clock = 1'b0;
  logic             clear;
  logic [CNT_W-1:0] count_in;
  logic             event_in;
  ts_t              out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ADDR_W:0]  level;
  logic             overflow;
  logic             wrap_pulse;

  int checks = 0;
  int errors = 0;
  int pulses;

  count_snapshot_fifo dut (
    .clock      (clock),
    .clear      (clear),
    .count_in   (count_in),
    .event_in   (event_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clock = ~clock;

  // One clock: outputs settle and the upstream counter advances 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    count_in = 3'(count_in + 3'd1);
  endtask

  task automatic wait_count(input logic [CNT_W-1:0] v);
    for (int i = 0; i < 8 && count_in != v; i++) tick();
  endtask

  task automatic pulse_at(input logic [CNT_W-1:0] v);
    wait_count(v);
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_level"},    32'(level),      32'd0);
    chk({tag, "_valid"},    32'(out_valid),  32'd0);
    chk({tag, "_overflow"}, 32'(overflow),   32'd0);
    chk({tag, "_data"},     32'(out_data),   32'h00);
    chk({tag, "_wrap"},     32'(wrap_pulse), 32'd0);
  endtask

  // Two-cycle clear aligned so count_in reads 0 afterwards with epoch 0.
  task automatic do_clear(input string tag);
    wait_count(3'd6);
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    chk_cleared(tag);
  endtask

  initial begin
    clear     = 1'b1;
    count_in  = '0;
    event_in  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    chk_cleared("reset");

    // Single capture at count 5, held three cycles, then popped.
    pulse_at(3'd5);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data",  32'(out_data),  32'h05);
    chk("t2_level", 32'(level),     32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_data",  32'(out_data),  32'h05);
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_pop_valid", 32'(out_valid), 32'd0);
    chk("t2_pop_level", 32'(level),     32'd0);

    // Capture coincident with a 7->0 wrap reports the new epoch.
    do_clear("t3_clear");
    wait_count(3'd7);
    tick();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    chk("t3_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t3_data",       32'(out_data),   32'h08);
    chk("t3_valid",      32'(out_valid),  32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_wrap_gone", 32'(wrap_pulse), 32'd0);
    chk("t3_empty",     32'(out_valid),  32'd0);

    // Fill to full, fifth capture dropped and flagged.
    do_clear("t4_clear");
    pulse_at(3'd1);
    pulse_at(3'd3);
    pulse_at(3'd5);
    pulse_at(3'd7);
    chk("t4_full_level",   32'(level),    32'd4);
    chk("t4_no_overflow",  32'(overflow), 32'd0);
    pulse_at(3'd1);
    chk("t4_drop_level",   32'(level),    32'd4);
    chk("t4_overflow",     32'(overflow), 32'd1);
    out_ready = 1'b1;
    chk("t4_drain0", 32'(out_data), 32'h01);
    tick();
    chk("t4_drain1", 32'(out_data), 32'h03);
    tick();
    chk("t4_drain2", 32'(out_data), 32'h05);
    tick();
    chk("t4_drain3", 32'(out_data), 32'h07);
    tick();
    out_ready = 1'b0;
    chk("t4_drained_valid", 32'(out_valid), 32'd0);
    chk("t4_drained_level", 32'(level),     32'd0);
    chk("t4_sticky",        32'(overflow),  32'd1);

    // Full with simultaneous push and pop.
    do_clear("t5_clear");
    pulse_at(3'd1);
    pulse_at(3'd3);
    pulse_at(3'd5);
    pulse_at(3'd7);
    wait_count(3'd1);
    chk("t5_full_before", 32'(level), 32'd4);
    event_in  = 1'b1;
    out_ready = 1'b1;
    tick();
    event_in  = 1'b0;
    chk("t5_level",    32'(level),    32'd4);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_drain0", 32'(out_data), 32'h03);
    tick();
    chk("t5_drain1", 32'(out_data), 32'h05);
    tick();
    chk("t5_drain2", 32'(out_data), 32'h07);
    tick();
    chk("t5_drain3", 32'(out_data), 32'h09);
    tick();
    out_ready = 1'b0;
    chk("t5_empty", 32'(out_valid), 32'd0);

    // Event held high ten cycles gives one entry.
    do_clear("t6_clear");
    event_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    event_in = 1'b0;
    chk("t6_held_level", 32'(level),     32'd1);
    chk("t6_held_valid", 32'(out_valid), 32'd1);
    chk("t6_held_data",  32'(out_data),  32'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_held_pop", 32'(level), 32'd0);

    // 32 wraps bring the epoch back to 0.
    do_clear("t6_clear2");
    pulses = 0;
    for (int i = 0; i < 257; i++) begin
      tick();
      if (wrap_pulse) pulses++;
    end
    chk("t6_wrap_count", 32'(pulses), 32'd32);
    pulse_at(3'd2);
    chk("t6_epoch_rollover", 32'(out_data), 32'h02);
    pulse_at(3'd4);
    pulse_at(3'd6);
    chk("t6_level3", 32'(level), 32'd3);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_cleared("t6_mid_clear");
    pulse_at(3'd2);
    chk("t6_epoch_reset", 32'(out_data), 32'h02);
    chk("t6_after_level", 32'(level),    32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
